// File: rtl/sha512_pad.sv
// sha512_pad: SHA-512 padder from a masked-word message FIFO to the engine.
// Ports: clk_i, rst_ni (async, active-low); hash_start_i / hash_process_i
//   control pulses; fifo_rvalid_i, fifo_rdata_i {data,mask}, fifo_rready_o;
//   shaf_rvalid_o, shaf_rdata_o, shaf_rready_i toward the engine;
//   done_o, err_o pulses; msg_len_o running bit count.
// Optional: `define SHA512_PAD_ERR_EN enables mask/protocol error checks.
module sha512_pad #(
  parameter bit ByteSwap = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hash_start_i,
  input  logic        hash_process_i,
  input  logic        fifo_rvalid_i,
  input  logic [71:0] fifo_rdata_i,
  output logic        fifo_rready_o,
  output logic        shaf_rvalid_o,
  output logic [63:0] shaf_rdata_o,
  input  logic        shaf_rready_i,
  output logic        done_o,
  output logic        err_o,
  output logic [63:0] msg_len_o
);

  typedef enum logic [2:0] {
    IDLE, RECV, PAD80, PAD00, LENHI, LENLO
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] len_q, len_d;
  logic [3:0]  idx_q, idx_d;
  logic        part_q, part_d;
  logic        proc_q, proc_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [63:0] data_w, pad_w;
  logic [7:0]  mask_w;
  logic [8:0]  mext_w;
  logic [3:0]  nbytes_w;
  logic        full_w, zero_w, emit_w;
  logic        fifo_hs, shaf_hs;

  // Lane select, optional byte reversal of the data word.
  always_comb begin
    mask_w = fifo_rdata_i[7:0];
    data_w = '0;
    for (int i = 0; i < 8; i++) begin
      data_w[8*i +: 8] = ByteSwap ? fifo_rdata_i[8+8*(7-i) +: 8]
                                  : fifo_rdata_i[8+8*i +: 8];
    end
  end

  // Keep qualified bytes; the first unqualified lane below a qualified
  // lane gets the 0x80 terminator, all lower lanes are zero.
  always_comb begin
    mext_w   = {1'b0, mask_w};
    pad_w    = '0;
    nbytes_w = '0;
    for (int i = 0; i < 8; i++) begin
      if (mext_w[i]) begin
        pad_w[8*i +: 8] = data_w[8*i +: 8];
        nbytes_w        = nbytes_w + 4'd1;
      end else if (mext_w[i+1]) begin
        pad_w[8*i +: 8] = 8'h80;
      end
    end
  end

  assign full_w = (mask_w == 8'hFF);
  assign zero_w = (mask_w == 8'h00);

`ifdef SHA512_PAD_ERR_EN
  logic [7:0] inv_w;
  logic       contig_w, bad_w;
  // Contiguous-from-bit-7 masks have an inverse of the form 2^k-1.
  assign inv_w    = ~mask_w;
  assign contig_w = ((inv_w & (inv_w + 8'd1)) == 8'd0);
  assign emit_w   = !zero_w && contig_w && !part_q;
  assign bad_w    = !zero_w && (!contig_w || part_q);
`else
  assign emit_w   = !zero_w;
`endif

  assign fifo_hs = fifo_rready_o;
  assign shaf_hs = shaf_rvalid_o && shaf_rready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      part_q  <= 1'b0;
      proc_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      part_q  <= part_d;
      proc_q  <= proc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    part_d  = part_q;
    proc_d  = proc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (shaf_hs) idx_d = idx_q + 4'd1;
    unique case (state_q)
      IDLE: begin
        if (hash_start_i) begin
          state_d = RECV;
          len_d   = '0;
          idx_d   = '0;
          part_d  = 1'b0;
          proc_d  = hash_process_i;
        end
      end
      RECV: begin
        if (hash_process_i) proc_d = 1'b1;
        if (fifo_hs && emit_w) begin
          len_d = len_q + {57'd0, nbytes_w, 3'd0};
          if (!full_w) part_d = 1'b1;
        end
`ifdef SHA512_PAD_ERR_EN
        if (fifo_hs && bad_w) err_d = 1'b1;
`endif
        if (proc_q && !fifo_rvalid_i) begin
          proc_d = 1'b0;
          if (!part_q)               state_d = PAD80;
          else if (idx_q == 4'd14)   state_d = LENHI;
          else                       state_d = PAD00;
        end
      end
      PAD80, PAD00: begin
        if (shaf_hs) begin
          state_d = (idx_d == 4'd14) ? LENHI : PAD00;
        end
      end
      LENHI: begin
        if (shaf_hs) state_d = LENLO;
      end
      LENLO: begin
        if (shaf_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SHA512_PAD_ERR_EN
    if (hash_start_i && state_q != IDLE) err_d = 1'b1;
`endif
  end

  always_comb begin
    fifo_rready_o = 1'b0;
    shaf_rvalid_o = 1'b0;
    shaf_rdata_o  = '0;
    unique case (state_q)
      IDLE: ;
      RECV: begin
        fifo_rready_o = fifo_rvalid_i && shaf_rready_i;
        shaf_rvalid_o = fifo_rvalid_i && emit_w;
        shaf_rdata_o  = pad_w;
      end
      PAD80: begin
        shaf_rvalid_o = 1'b1;
        shaf_rdata_o  = 64'h8000_0000_0000_0000;
      end
      PAD00, LENHI: begin
        shaf_rvalid_o = 1'b1;
      end
      LENLO: begin
        shaf_rvalid_o = 1'b1;
        shaf_rdata_o  = len_q;
      end
      default: ;
    endcase
  end

  assign done_o    = done_q;
  assign err_o     = err_q;
  assign msg_len_o = len_q;

endmodule
